// File: rtl/spinner_encoder.sv
// spinner_encoder
//   Turns digital up/down joystick input into a 2-bit quadrature (Gray-code)
//   dial phase for paddle/dial games. One instance per player. Steps are
//   time-based. Holding a direction accelerates the stepping. pause freezes
//   all motion.
//
// Ports
//   clk_sys  in   system clock (12 MHz)
//   reset_n  in   asynchronous active-low reset
//   enable   in   spinner mode; when low, dial passes through {down, up}
//   up       in   move in the negative direction
//   down     in   move in the positive direction
//   invert   in   swap the meaning of up and down
//   pause    in   freeze FSM, counters and phase
//   dial     out  quadrature phase to the core (registered, active-high)
//   moving   out  high while running (registered)
//
// Optional feature
//   SPINNER_IDLE_RELEASE_EN: after IDLE_TIMEOUT cycles in IDLE, walk the
//   phase back to 11 one Gray step per cycle along the shortest path.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no valid press; phase held (or walked home with the macro)
// ST_RUN_SLOW | stepping every DIV_SLOW cycles, counting steps toward accel
// ST_RUN_FAST | stepping every DIV_FAST cycles, step count saturated

module spinner_encoder #(
    parameter int DIV_SLOW     = 120000,
    parameter int DIV_FAST     = 40000,
    parameter int ACCEL_STEPS  = 8,
    parameter int IDLE_TIMEOUT = 600000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       up,
    input  logic       down,
    input  logic       invert,
    input  logic       pause,
    output logic [1:0] dial,
    output logic       moving
);

    localparam int MAX_A = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int MAX_B = (ACCEL_STEPS > IDLE_TIMEOUT) ? ACCEL_STEPS : IDLE_TIMEOUT;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] SLOW_TC = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] FAST_TC = CW'(DIV_FAST - 1);
    localparam logic [CW-1:0] ACCEL_N = CW'(ACCEL_STEPS);
`ifdef SPINNER_IDLE_RELEASE_EN
    localparam logic [CW-1:0] IDLE_TC = CW'(IDLE_TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_SLOW,
        ST_RUN_FAST
    } state_t;

    state_t          state, state_n;
    logic            up_r, down_r, invert_r;
    logic [1:0]      ph, ph_n;
    logic            dir_q, dir_n;
    logic [CW-1:0]   div_cnt, div_n;
    logic [CW-1:0]   step_cnt, step_n;
`ifdef SPINNER_IDLE_RELEASE_EN
    logic [CW-1:0]   idle_cnt, idle_n;
`endif

    logic            press_valid;
    logic            dir_in;
    logic [CW-1:0]   run_tc;

    // pos=1: 11->01->00->10->11, pos=0: reverse
    function automatic logic [1:0] gray_step(input logic [1:0] p, input logic pos);
        logic [1:0] r;
        r = 2'b11;
        if (pos) begin
            case (p)
                2'b11:   r = 2'b01;
                2'b01:   r = 2'b00;
                2'b00:   r = 2'b10;
                default: r = 2'b11;
            endcase
        end else begin
            case (p)
                2'b11:   r = 2'b10;
                2'b10:   r = 2'b00;
                2'b00:   r = 2'b01;
                default: r = 2'b11;
            endcase
        end
        return r;
    endfunction

    // Exactly one of up/down counts as a press; both or neither is a release.
    assign press_valid = up_r ^ down_r;
    assign dir_in      = down_r ^ invert_r;
    assign run_tc      = (state == ST_RUN_FAST) ? FAST_TC : SLOW_TC;

    always_comb begin
        state_n = state;
        ph_n    = ph;
        dir_n   = dir_q;
        div_n   = div_cnt;
        step_n  = step_cnt;
`ifdef SPINNER_IDLE_RELEASE_EN
        idle_n  = idle_cnt;
`endif
        if (!enable) begin
            state_n = ST_IDLE;
            ph_n    = 2'b11;
            div_n   = '0;
            step_n  = '0;
`ifdef SPINNER_IDLE_RELEASE_EN
            idle_n  = '0;
`endif
        end else if (!pause) begin
            case (state)
                ST_IDLE: begin
                    div_n  = '0;
                    step_n = '0;
                    if (press_valid) begin
                        ph_n    = gray_step(ph, dir_in);
                        dir_n   = dir_in;
                        state_n = ST_RUN_SLOW;
`ifdef SPINNER_IDLE_RELEASE_EN
                        idle_n  = '0;
`endif
                    end
`ifdef SPINNER_IDLE_RELEASE_EN
                    else if (idle_cnt != IDLE_TC) begin
                        idle_n = idle_cnt + ONE;
                    end else if (ph != 2'b11) begin
                        // 01 goes home backwards, 10 and 00 go forwards
                        ph_n = gray_step(ph, ph != 2'b01);
                    end
`endif
                end
                ST_RUN_SLOW, ST_RUN_FAST: begin
                    if (!press_valid) begin
                        state_n = ST_IDLE;
                        div_n   = '0;
                        step_n  = '0;
`ifdef SPINNER_IDLE_RELEASE_EN
                        idle_n  = '0;
`endif
                    end else if (dir_in != dir_q) begin
                        // reversal steps immediately and restarts slow mode
                        ph_n    = gray_step(ph, dir_in);
                        dir_n   = dir_in;
                        div_n   = '0;
                        step_n  = '0;
                        state_n = ST_RUN_SLOW;
                    end else if (div_cnt == run_tc) begin
                        ph_n  = gray_step(ph, dir_q);
                        div_n = '0;
                        if (state == ST_RUN_SLOW) begin
                            step_n = step_cnt + ONE;
                            if (step_cnt + ONE == ACCEL_N) begin
                                state_n = ST_RUN_FAST;
                            end
                        end
                    end else begin
                        div_n = div_cnt + ONE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    div_n   = '0;
                    step_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            up_r     <= 1'b0;
            down_r   <= 1'b0;
            invert_r <= 1'b0;
            state    <= ST_IDLE;
            ph       <= 2'b11;
            dir_q    <= 1'b0;
            div_cnt  <= '0;
            step_cnt <= '0;
`ifdef SPINNER_IDLE_RELEASE_EN
            idle_cnt <= '0;
`endif
            dial     <= 2'b11;
            moving   <= 1'b0;
        end else begin
            up_r     <= up;
            down_r   <= down;
            invert_r <= invert;
            state    <= state_n;
            ph       <= ph_n;
            dir_q    <= dir_n;
            div_cnt  <= div_n;
            step_cnt <= step_n;
`ifdef SPINNER_IDLE_RELEASE_EN
            idle_cnt <= idle_n;
`endif
            // pass-through value equals next cycle's {down_r, up_r}
            dial     <= enable ? ph_n : {down, up};
            moving   <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_spinner_encoder.sv
// tb_spinner_encoder
//   Directed bench for spinner_encoder with DIV_SLOW=8, DIV_FAST=2,
//   ACCEL_STEPS=4, IDLE_TIMEOUT=20. Inputs are driven and outputs sampled
//   1 ns after the rising clock edge.

module tb_spinner_encoder;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic       up      = 1'b0;
    logic       down    = 1'b1;
    logic       invert  = 1'b0;
    logic       pause   = 1'b0;
    logic [1:0] dial;
    logic       moving;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    spinner_encoder #(
        .DIV_SLOW     (8),
        .DIV_FAST     (2),
        .ACCEL_STEPS  (4),
        .IDLE_TIMEOUT (20)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .enable  (enable),
        .up      (up),
        .down    (down),
        .invert  (invert),
        .pause   (pause),
        .dial    (dial),
        .moving  (moving)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        // reset with down held
        tick(3);
        chk("rst_dial", dial, 2'b11);
        chk("rst_moving", moving, 1'b0);

        down    = 1'b0;
        enable  = 1'b1;
        reset_n = 1'b1;
        tick(2);
        chk("idle_dial", dial, 2'b11);
        chk("idle_moving", moving, 1'b0);

        // press down: first step two edges later, then slow 8-cycle steps
        down = 1'b1;
        tick(1);
        chk("lat_n1", dial, 2'b11);
        tick(1);
        chk("step1_01", dial, 2'b01);
        chk("step1_moving", moving, 1'b1);
        tick(7);
        chk("slow_hold", dial, 2'b01);
        tick(1);
        chk("slow_00", dial, 2'b00);
        tick(8);
        chk("slow_10", dial, 2'b10);
        tick(8);
        chk("slow_11", dial, 2'b11);
        tick(8);
        chk("slow_last_01", dial, 2'b01);
        // now fast: every 2 cycles
        tick(1);
        chk("fast_hold", dial, 2'b01);
        tick(1);
        chk("fast_00", dial, 2'b00);
        tick(2);
        chk("fast_10", dial, 2'b10);
        tick(2);
        chk("fast_11", dial, 2'b11);
        chk("fast_moving", moving, 1'b1);

        // release right after a fast step: the step due 2 cycles later must not occur
        down = 1'b0;
        tick(1);
        chk("rel_n1_dial", dial, 2'b11);
        chk("rel_n1_moving", moving, 1'b1);
        tick(1);
        chk("rel_n2_dial", dial, 2'b11);
        chk("rel_n2_moving", moving, 1'b0);
        tick(4);
        chk("rel_hold", dial, 2'b11);

        // direction reversal at ph=00
        down = 1'b1;
        tick(2);
        chk("rev_01", dial, 2'b01);
        tick(8);
        chk("rev_00", dial, 2'b00);
        down = 1'b0;
        up   = 1'b1;
        tick(1);
        chk("rev_sw_n1", dial, 2'b00);
        tick(1);
        chk("rev_neg_01", dial, 2'b01);
        tick(7);
        chk("rev_slow_hold", dial, 2'b01);
        tick(1);
        chk("rev_neg_11", dial, 2'b11);
        up = 1'b0;
        tick(2);
        chk("rev_rel_moving", moving, 1'b0);
        chk("rev_rel_dial", dial, 2'b11);

        // invert with down held: negative sequence
        invert = 1'b1;
        down   = 1'b1;
        tick(2);
        chk("inv_10", dial, 2'b10);
        tick(8);
        chk("inv_00", dial, 2'b00);
        down = 1'b0;
        tick(2);
        chk("inv_rel_moving", moving, 1'b0);

        // both pressed counts as released (short enough to stay below idle timeout)
        invert = 1'b0;
        up     = 1'b1;
        down   = 1'b1;
        tick(12);
        chk("both_dial", dial, 2'b00);
        chk("both_moving", moving, 1'b0);

        // pause mid-run
        up = 1'b0;
        tick(2);
        chk("pz_start_10", dial, 2'b10);
        tick(3);
        pause = 1'b1;
        tick(25);
        chk("pz_mid", dial, 2'b10);
        tick(25);
        chk("pz_end", dial, 2'b10);
        chk("pz_moving", moving, 1'b1);
        pause = 1'b0;
        tick(4);
        chk("pz_resume_hold", dial, 2'b10);
        tick(1);
        chk("pz_resume_11", dial, 2'b11);
        down = 1'b0;
        tick(2);
        chk("pz_rel_moving", moving, 1'b0);

        // disabled mode: pass-through and forced phase
        down = 1'b1;
        tick(2);
        chk("dis_run_01", dial, 2'b01);
        enable = 1'b0;
        tick(1);
        chk("dis_pass_10", dial, 2'b10);
        chk("dis_moving", moving, 1'b0);
        down = 1'b0;
        up   = 1'b1;
        tick(1);
        chk("dis_pass_01", dial, 2'b01);
        up = 1'b0;
        tick(1);
        chk("dis_pass_00", dial, 2'b00);
        enable = 1'b1;
        tick(1);
        chk("dis_forced_11", dial, 2'b11);

        // asynchronous reset mid-run
        down = 1'b1;
        tick(2);
        chk("arst_run_01", dial, 2'b01);
        reset_n = 1'b0;
        #1;
        chk("arst_dial", dial, 2'b11);
        chk("arst_moving", moving, 1'b0);
        down = 1'b0;
        #2;
        reset_n = 1'b1;
        tick(2);
        chk("arst_after", dial, 2'b11);

        // idle behaviour after release at ph=00
        down = 1'b1;
        tick(2);
        chk("idl_01", dial, 2'b01);
        tick(8);
        chk("idl_00", dial, 2'b00);
        down = 1'b0;
        tick(2);
        chk("idl_enter_moving", moving, 1'b0);
`ifdef SPINNER_IDLE_RELEASE_EN
        tick(19);
        chk("idl_wait_00", dial, 2'b00);
        tick(1);
        chk("idl_walk_10", dial, 2'b10);
        tick(1);
        chk("idl_walk_11", dial, 2'b11);
        tick(3);
        chk("idl_home", dial, 2'b11);
`else
        tick(40);
        chk("idl_hold_00", dial, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
